// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcodes, entry layout, FSM encoding.
package fetch_queue_pkg;

   // RV32 control-flow opcodes that change the sequential fetch stream
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   // Fetch-entry field widths; the two address fields (pc, stack_top) scale with ADDR_W
   localparam int unsigned INSTR_W = 32;
   localparam int unsigned C_W     = 1;
   localparam int unsigned PRED_W  = 1;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDrop = 2'd2
   } fetch_state_e;

   // Entry layout: {instruction, c, pc, br_prediction, stack_top}
   function automatic int unsigned entry_width(int unsigned addr_w);
      return INSTR_W + C_W + PRED_W + 2 * addr_w;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Ring buffer holding fetched instruction entries; pop_data shows the oldest entry.
module fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    push,
   input  logic [WIDTH-1:0]        push_data,
   input  logic                    pop,
   output logic [WIDTH-1:0]        pop_data,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;

   // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         if (push && !pop) begin
            count_q <= count_q + (PTR_W+1)'(1);
         end else if (pop && !push) begin
            count_q <= count_q - (PTR_W+1)'(1);
         end
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push && !clear && !rst) mem_q[wr_ptr_q] <= push_data;
   end

   assign pop_data = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues one icache request at a time, predicts the next PC
// from each response and buffers entries for the decoder in a small FIFO.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 17
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    pc_rst,
   input  logic [ADDR_W-1:0]       new_pc,
   output logic [ADDR_W-1:0]       branch_query_addr,
   input  logic                    branch_query_prediction,
   input  logic [ADDR_W-1:0]       stack_top,
   output logic                    icache_fetch_en,
   output logic [ADDR_W-1:0]       icache_fetch_addr,
   input  logic                    icache_out_en,
   input  logic [31:0]             icache_instruction,
   input  logic                    icache_cinstruction,
   input  logic                    out_ready,
   output logic                    instruction_en,
   output logic [31:0]             instruction,
   output logic                    c_instruction,
   output logic [ADDR_W-1:0]       pc_out,
   output logic [ADDR_W-1:0]       instruction_addr_prediction,
   output logic                    instruction_br_prediction,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
   localparam int unsigned ENTRY_W = entry_width(ADDR_W);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W:0]   FULL_NEXT = (CNT_W+1)'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] next_pc, len;
   logic signed [31:0] b_imm, j_imm;
   logic              push, pop;
   logic [CNT_W:0]    cnt_after_push;
   logic [ENTRY_W-1:0] push_data, pop_data;

   // Immediates are sign-extended to 32 bits, then truncated/extended to ADDR_W
   always_comb begin
      b_imm = {{20{icache_instruction[31]}}, icache_instruction[7], icache_instruction[30:25],
               icache_instruction[11:8], 1'b0};
      j_imm = {{12{icache_instruction[31]}}, icache_instruction[19:12], icache_instruction[20],
               icache_instruction[30:21], 1'b0};
      len   = icache_cinstruction ? ADDR_W'(2) : ADDR_W'(4);
      case (icache_instruction[6:0])
         OPC_BRANCH: next_pc = branch_query_prediction ? fetch_pc_q + ADDR_W'(b_imm)
                                                       : fetch_pc_q + len;
         OPC_JALR:   next_pc = stack_top;
         OPC_JAL:    next_pc = fetch_pc_q + ADDR_W'(j_imm);
         default:    next_pc = fetch_pc_q + len;
      endcase
   end

   // Pop is independent of the push this cycle: an entry written now is visible next cycle
   assign pop            = (count != '0) && out_ready && !pc_rst;
   assign cnt_after_push = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);

   // Fetch FSM next state, request strobe and push decision
   always_comb begin
      state_d           = state_q;
      fetch_pc_d        = fetch_pc_q;
      icache_fetch_en   = 1'b0;
      icache_fetch_addr = fetch_pc_q;
      push              = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pc_rst) begin
               fetch_pc_d = new_pc;
            end else if (count < FULL_CNT) begin
               icache_fetch_en = 1'b1;
               state_d         = StWait;
            end
         end
         StWait: begin
            if (pc_rst) begin
               fetch_pc_d = new_pc;
               state_d    = icache_out_en ? StIdle : StDrop;
            end else if (icache_out_en) begin
               push              = 1'b1;
               fetch_pc_d        = next_pc;
               icache_fetch_addr = next_pc;
               if (cnt_after_push < FULL_NEXT) begin
                  icache_fetch_en = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StDrop: begin
            // The outstanding response belongs to a flushed stream and is discarded
            if (pc_rst) fetch_pc_d = new_pc;
            if (icache_out_en) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (rst) begin
         icache_fetch_en = 1'b0;
         push            = 1'b0;
      end
   end

   // FSM state and fetch PC registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         fetch_pc_q <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign branch_query_addr = fetch_pc_q;
   assign push_data = {icache_instruction, icache_cinstruction, fetch_pc_q,
                       branch_query_prediction, stack_top};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (pc_rst),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .count     (count)
   );

   // Registered decoder interface; instruction_en is a one-cycle strobe per popped entry
   always_ff @(posedge clk) begin
      if (rst) begin
         instruction_en              <= 1'b0;
         instruction                 <= '0;
         c_instruction               <= 1'b0;
         pc_out                      <= '0;
         instruction_br_prediction   <= 1'b0;
         instruction_addr_prediction <= '0;
      end else if (pc_rst) begin
         instruction_en <= 1'b0;
      end else if (pop) begin
         instruction_en <= 1'b1;
         {instruction, c_instruction, pc_out, instruction_br_prediction,
          instruction_addr_prediction} <= pop_data;
      end else begin
         instruction_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run against
// a queue-based reference model of the fetch stream.
module tb_fetch_queue;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 17;
   localparam logic [31:0] ADDI = 32'h00100093;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pc_rst;
   logic [ADDR_W-1:0] new_pc;
   logic [ADDR_W-1:0] branch_query_addr;
   logic              branch_query_prediction;
   logic [ADDR_W-1:0] stack_top;
   logic              icache_fetch_en;
   logic [ADDR_W-1:0] icache_fetch_addr;
   logic              icache_out_en;
   logic [31:0]       icache_instruction;
   logic              icache_cinstruction;
   logic              out_ready;
   logic              instruction_en;
   logic [31:0]       instruction;
   logic              c_instruction;
   logic [ADDR_W-1:0] pc_out;
   logic [ADDR_W-1:0] instruction_addr_prediction;
   logic              instruction_br_prediction;
   logic [2:0]        count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]       ins;
      logic              c;
      logic [ADDR_W-1:0] pc;
      logic              pred;
      logic [ADDR_W-1:0] st;
   } ent_t;

   fetch_queue #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk                         (clk),
      .rst                         (rst),
      .pc_rst                      (pc_rst),
      .new_pc                      (new_pc),
      .branch_query_addr           (branch_query_addr),
      .branch_query_prediction     (branch_query_prediction),
      .stack_top                   (stack_top),
      .icache_fetch_en             (icache_fetch_en),
      .icache_fetch_addr           (icache_fetch_addr),
      .icache_out_en               (icache_out_en),
      .icache_instruction          (icache_instruction),
      .icache_cinstruction         (icache_cinstruction),
      .out_ready                   (out_ready),
      .instruction_en              (instruction_en),
      .instruction                 (instruction),
      .c_instruction               (c_instruction),
      .pc_out                      (pc_out),
      .instruction_addr_prediction (instruction_addr_prediction),
      .instruction_br_prediction   (instruction_br_prediction),
      .count                       (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] enc_branch(input int imm);
      logic [12:0] b;
      b = imm[12:0];
      return {b[12], b[10:5], 5'd2, 5'd1, 3'b000, b[4:1], b[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_jal(input int imm);
      logic [20:0] j;
      j = imm[20:0];
      return {j[20], j[10:1], j[11], j[19:12], 5'd1, 7'b1101111};
   endfunction

   function automatic logic [31:0] enc_jalr();
      return {12'd0, 5'd1, 3'b000, 5'd1, 7'b1100111};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      pc_rst                  = 1'b0;
      new_pc                  = '0;
      branch_query_prediction = 1'b0;
      stack_top               = '0;
      icache_out_en           = 1'b0;
      icache_instruction      = ADDI;
      icache_cinstruction     = 1'b0;
      out_ready               = 1'b0;
   endtask

   // Leaves time just after an edge with rst low: first post-reset cycle
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Answers n consecutive requests with 4-byte ADDIs
   task automatic run_addi(input int n);
      for (int i = 0; i < n; i++) begin
         cyc();
         icache_out_en       = 1'b1;
         icache_instruction  = ADDI;
         icache_cinstruction = 1'b0;
      end
   endtask

   task automatic test_reset();
      idle_inputs();
      rst           = 1'b1;
      out_ready     = 1'b1;
      icache_out_en = 1'b1;
      cyc();
      cyc();
      checks++;
      if (instruction_en !== 1'b0) begin
         errors++; $display("FAIL reset_ien: got %b expected 0", instruction_en);
      end
      checks++;
      if (count !== 3'd0) begin
         errors++; $display("FAIL reset_count: got %0d expected 0", count);
      end
      checks++;
      if (pc_out !== '0 || instruction !== '0) begin
         errors++; $display("FAIL reset_outputs: pc_out %h instr %h expected 0", pc_out, instruction);
      end
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL reset_fetch_in_rst: got %b expected 0", icache_fetch_en);
      end
      rst           = 1'b0;
      icache_out_en = 1'b0;
      #1;
      checks++;
      if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== '0) begin
         errors++;
         $display("FAIL reset_first_fetch: en %b addr %h expected 1 / 0", icache_fetch_en,
                  icache_fetch_addr);
      end
   endtask

   task automatic test_sequential();
      do_reset();
      out_ready = 1'b1;
      cyc();
      for (int k = 1; k <= 6; k++) begin
         icache_out_en       = 1'b1;
         icache_instruction  = ADDI;
         icache_cinstruction = 1'b0;
         #1;
         checks++;
         if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== ADDR_W'(4 * k)) begin
            errors++;
            $display("FAIL seq_fetch k=%0d: en %b addr %h expected 1 / %h", k, icache_fetch_en,
                     icache_fetch_addr, 4 * k);
         end
         if (k >= 3) begin
            checks++;
            if (instruction_en !== 1'b1 || pc_out !== ADDR_W'(4 * (k - 3))) begin
               errors++;
               $display("FAIL seq_out k=%0d: en %b pc %h expected 1 / %h", k, instruction_en,
                        pc_out, 4 * (k - 3));
            end
         end
         if (k >= 2) begin
            checks++;
            if (count !== 3'd1) begin
               errors++; $display("FAIL seq_count k=%0d: got %0d expected 1", k, count);
            end
         end
         cyc();
      end
      icache_out_en = 1'b0;
   endtask

   task automatic test_full();
      do_reset();
      out_ready = 1'b0;
      cyc();
      for (int k = 1; k <= 4; k++) begin
         icache_out_en      = 1'b1;
         icache_instruction = ADDI;
         #1;
         checks++;
         if (icache_fetch_en !== (k < 4)) begin
            errors++;
            $display("FAIL full_fill k=%0d: fetch_en %b expected %b", k, icache_fetch_en, k < 4);
         end
         cyc();
      end
      icache_out_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (icache_fetch_en !== 1'b0 || count !== 3'd4 || instruction_en !== 1'b0) begin
            errors++;
            $display("FAIL full_hold: fetch_en %b count %0d ien %b expected 0 / 4 / 0",
                     icache_fetch_en, count, instruction_en);
         end
         cyc();
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL full_pop_cycle: fetch_en %b expected 0", icache_fetch_en);
      end
      cyc();
      out_ready = 1'b0;
      #1;
      checks++;
      if (instruction_en !== 1'b1 || pc_out !== '0 || count !== 3'd3) begin
         errors++;
         $display("FAIL full_pop: ien %b pc %h count %0d expected 1 / 0 / 3", instruction_en,
                  pc_out, count);
      end
      checks++;
      if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== ADDR_W'(16)) begin
         errors++;
         $display("FAIL full_refetch: en %b addr %h expected 1 / 10", icache_fetch_en,
                  icache_fetch_addr);
      end
      cyc();
      #1;
      checks++;
      if (instruction_en !== 1'b0 || icache_fetch_en !== 1'b0) begin
         errors++;
         $display("FAIL full_after: ien %b fetch_en %b expected 0 / 0", instruction_en,
                  icache_fetch_en);
      end
   endtask

   task automatic test_branch();
      logic found;
      for (int p = 0; p < 2; p++) begin
         do_reset();
         out_ready = 1'b1;
         run_addi(4);
         cyc();
         icache_out_en           = 1'b1;
         icache_instruction      = enc_branch(-8);
         icache_cinstruction     = (p == 1);
         branch_query_prediction = (p == 0);
         stack_top               = ADDR_W'(17'h00abc);
         #1;
         checks++;
         if (icache_fetch_en !== 1'b1
             || icache_fetch_addr !== ((p == 1) ? ADDR_W'(17'h12) : ADDR_W'(17'h08))) begin
            errors++;
            $display("FAIL branch_target p=%0d: en %b addr %h", p, icache_fetch_en,
                     icache_fetch_addr);
         end
         cyc();
         icache_out_en = 1'b0;
         found = 1'b0;
         for (int t = 0; t < 8 && !found; t++) begin
            if (instruction_en === 1'b1 && pc_out === ADDR_W'(17'h10)) found = 1'b1;
            else cyc();
         end
         checks++;
         if (!found) begin
            errors++; $display("FAIL branch_entry p=%0d: entry for pc 10 never emitted", p);
         end else if (instruction_br_prediction !== (p == 0) || c_instruction !== (p == 1)) begin
            errors++;
            $display("FAIL branch_entry p=%0d: pred %b c %b", p, instruction_br_prediction,
                     c_instruction);
         end
      end
   endtask

   task automatic test_jumps();
      logic found;
      do_reset();
      out_ready = 1'b1;
      run_addi(8);
      cyc();
      icache_out_en      = 1'b1;
      icache_instruction = enc_jalr();
      stack_top          = ADDR_W'(17'h1f0);
      #1;
      checks++;
      if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== ADDR_W'(17'h1f0)) begin
         errors++;
         $display("FAIL jalr_target: en %b addr %h expected 1 / 1f0", icache_fetch_en,
                  icache_fetch_addr);
      end
      cyc();
      icache_out_en = 1'b0;
      found = 1'b0;
      for (int t = 0; t < 8 && !found; t++) begin
         if (instruction_en === 1'b1 && pc_out === ADDR_W'(17'h20)) found = 1'b1;
         else cyc();
      end
      checks++;
      if (!found || instruction_addr_prediction !== ADDR_W'(17'h1f0)) begin
         errors++;
         $display("FAIL jalr_entry: found %b addr_pred %h expected 1 / 1f0", found,
                  instruction_addr_prediction);
      end
      do_reset();
      pc_rst = 1'b1;
      new_pc = ADDR_W'(17'h1fff0);
      #1;
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL jal_redirect_idle: fetch_en %b expected 0", icache_fetch_en);
      end
      cyc();
      pc_rst = 1'b0;
      #1;
      checks++;
      if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== ADDR_W'(17'h1fff0)) begin
         errors++;
         $display("FAIL jal_fetch: en %b addr %h expected 1 / 1fff0", icache_fetch_en,
                  icache_fetch_addr);
      end
      cyc();
      icache_out_en      = 1'b1;
      icache_instruction = enc_jal(32'h100);
      #1;
      checks++;
      if (icache_fetch_en !== 1'b1 || icache_fetch_addr !== ADDR_W'(17'h000f0)) begin
         errors++;
         $display("FAIL jal_wrap: en %b addr %h expected 1 / 000f0", icache_fetch_en,
                  icache_fetch_addr);
      end
      cyc();
      icache_out_en = 1'b0;
   endtask

   task automatic test_flush_wait();
      do_reset();
      out_ready = 1'b1;
      cyc();
      pc_rst = 1'b1;
      new_pc = ADDR_W'(17'h400);
      #1;
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL flush_wait_req: fetch_en %b expected 0", icache_fetch_en);
      end
      cyc();
      pc_rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (icache_fetch_en !== 1'b0) begin
            errors++; $display("FAIL flush_wait_drop: fetch_en %b expected 0", icache_fetch_en);
         end
         cyc();
      end
      icache_out_en      = 1'b1;
      icache_instruction = ADDI;
      #1;
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL flush_wait_resp: fetch_en %b expected 0", icache_fetch_en);
      end
      cyc();
      icache_out_en = 1'b0;
      #1;
      checks++;
      if (count !== 3'd0 || instruction_en !== 1'b0 || icache_fetch_en !== 1'b1
          || icache_fetch_addr !== ADDR_W'(17'h400)) begin
         errors++;
         $display("FAIL flush_wait_refetch: count %0d ien %b en %b addr %h expected 0/0/1/400",
                  count, instruction_en, icache_fetch_en, icache_fetch_addr);
      end
   endtask

   task automatic test_flush_coincident();
      do_reset();
      out_ready = 1'b0;
      cyc();
      icache_out_en      = 1'b1;
      icache_instruction = ADDI;
      cyc();
      out_ready = 1'b1;
      pc_rst    = 1'b1;
      new_pc    = ADDR_W'(17'h80);
      #1;
      checks++;
      if (icache_fetch_en !== 1'b0) begin
         errors++; $display("FAIL flush_coinc_req: fetch_en %b expected 0", icache_fetch_en);
      end
      cyc();
      icache_out_en = 1'b0;
      pc_rst        = 1'b0;
      out_ready     = 1'b0;
      #1;
      checks++;
      if (instruction_en !== 1'b0 || count !== 3'd0 || icache_fetch_en !== 1'b1
          || icache_fetch_addr !== ADDR_W'(17'h80)) begin
         errors++;
         $display("FAIL flush_coinc: ien %b count %0d en %b addr %h expected 0/0/1/80",
                  instruction_en, count, icache_fetch_en, icache_fetch_addr);
      end
   endtask

   task automatic test_random();
      ent_t              q[$];
      ent_t              exp_out;
      logic              outstanding, dropping, pend, resp, pop, push, exp_ien, exp_fen;
      int                lat, pend_kind, pend_imm;
      logic [31:0]       pend_ins;
      logic              pend_c;
      logic [ADDR_W-1:0] exp_pc, tgt, len;
      outstanding = 1'b0; dropping = 1'b0; pend = 1'b0; exp_ien = 1'b0;
      lat = 0; pend_kind = 0; pend_imm = 0; pend_ins = ADDI; pend_c = 1'b0; exp_pc = '0;
      exp_out = '{ins: '0, c: 1'b0, pc: '0, pred: 1'b0, st: '0};
      do_reset();
      for (int i = 0; i < 600; i++) begin
         checks++;
         if (instruction_en !== exp_ien) begin
            errors++; $display("FAIL rnd_ien cyc %0d: got %b expected %b", i, instruction_en, exp_ien);
         end
         if (exp_ien) begin
            checks++;
            if (instruction !== exp_out.ins || c_instruction !== exp_out.c
                || pc_out !== exp_out.pc || instruction_br_prediction !== exp_out.pred
                || instruction_addr_prediction !== exp_out.st) begin
               errors++;
               $display("FAIL rnd_entry cyc %0d: got %h/%b/%h/%b/%h expected %h/%b/%h/%b/%h", i,
                        instruction, c_instruction, pc_out, instruction_br_prediction,
                        instruction_addr_prediction, exp_out.ins, exp_out.c, exp_out.pc,
                        exp_out.pred, exp_out.st);
            end
         end
         checks++;
         if (count !== 3'(q.size())) begin
            errors++; $display("FAIL rnd_count cyc %0d: got %0d expected %0d", i, count, q.size());
         end

         resp                    = pend && (lat == 0);
         icache_out_en           = resp;
         icache_instruction      = resp ? pend_ins : $urandom;
         icache_cinstruction     = resp ? pend_c : 1'($urandom);
         out_ready               = ($urandom_range(0, 3) < ((i < 300) ? 1 : 3));
         pc_rst                  = ($urandom_range(0, 15) == 0);
         new_pc                  = ADDR_W'($urandom) & ~ADDR_W'(1);
         branch_query_prediction = 1'($urandom);
         stack_top               = ADDR_W'($urandom) & ~ADDR_W'(1);
         #1;

         pop  = (q.size() > 0) && out_ready && !pc_rst;
         push = resp && !dropping && !pc_rst;
         len  = pend_c ? ADDR_W'(2) : ADDR_W'(4);
         case (pend_kind)
            1:       tgt = branch_query_prediction ? ADDR_W'(int'(exp_pc) + pend_imm) : exp_pc + len;
            2:       tgt = ADDR_W'(int'(exp_pc) + pend_imm);
            3:       tgt = stack_top;
            default: tgt = exp_pc + len;
         endcase
         exp_fen = !pc_rst && ((!outstanding && q.size() < DEPTH)
                               || (push && (q.size() + 1 - (pop ? 1 : 0)) < DEPTH));
         checks++;
         if (icache_fetch_en !== exp_fen) begin
            errors++;
            $display("FAIL rnd_fetch_en cyc %0d: got %b expected %b", i, icache_fetch_en, exp_fen);
         end
         if (exp_fen) begin
            checks++;
            if (icache_fetch_addr !== (outstanding ? tgt : exp_pc)) begin
               errors++;
               $display("FAIL rnd_fetch_addr cyc %0d: got %h expected %h", i, icache_fetch_addr,
                        outstanding ? tgt : exp_pc);
            end
         end
         if (outstanding && !dropping) begin
            checks++;
            if (branch_query_addr !== exp_pc) begin
               errors++;
               $display("FAIL rnd_query cyc %0d: got %h expected %h", i, branch_query_addr, exp_pc);
            end
         end

         exp_ien = pop;
         if (pop) exp_out = q.pop_front();
         if (push) begin
            q.push_back('{ins: pend_ins, c: pend_c, pc: exp_pc, pred: branch_query_prediction,
                          st: stack_top});
            exp_pc = tgt;
         end
         if (pc_rst) begin
            q.delete();
            exp_pc = new_pc;
         end
         if (resp) begin
            outstanding = 1'b0;
            dropping    = 1'b0;
            pend        = 1'b0;
         end else if (pend) begin
            lat--;
         end
         if (pc_rst && outstanding) dropping = 1'b1;
         if (exp_fen) begin
            outstanding = 1'b1;
            pend        = 1'b1;
            lat         = $urandom_range(0, 2);
            pend_kind   = $urandom_range(0, 3);
            pend_c      = 1'($urandom);
            case (pend_kind)
               1: begin
                  pend_imm = 2 * int'($urandom_range(0, 4095)) - 4096;
                  pend_ins = enc_branch(pend_imm);
               end
               2: begin
                  pend_imm = 2 * int'($urandom_range(0, 1048575)) - 1048576;
                  pend_ins = enc_jal(pend_imm);
               end
               3: begin
                  pend_imm = 0;
                  pend_ins = enc_jalr();
               end
               default: begin
                  pend_imm = 0;
                  pend_ins = ADDI;
               end
            endcase
         end
         cyc();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_sequential();
      test_full();
      test_branch();
      test_jumps();
      test_flush_wait();
      test_flush_coincident();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries; SHALL be a power of two >= 2.
REQ-002 Parameter ADDR_W, default 17, width of every program-counter and address signal.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 pc_rst  in  1  flush request from commit (mispredict); new_pc  in  ADDR_W  redirect target.
REQ-006 branch_query_addr  out  ADDR_W  PC of in-flight fetch; branch_query_prediction  in  1  taken prediction for that PC; stack_top  in  ADDR_W  return-address-stack top.
REQ-007 icache_fetch_en  out  1  fetch request strobe; icache_fetch_addr  out  ADDR_W  fetch address.
REQ-008 icache_out_en  in  1  response valid; icache_instruction  in  32  expanded instruction; icache_cinstruction  in  1  original was 16-bit.
REQ-009 out_ready  in  1  decoder/ROB/RS can accept one instruction this cycle.
REQ-010 instruction_en  out  1; instruction  out  32; c_instruction  out  1; pc_out  out  ADDR_W; instruction_addr_prediction  out  ADDR_W; instruction_br_prediction  out  1.
REQ-011 count  out  $clog2(DEPTH)+1  current number of valid entries.

Function
REQ-012 Fetch FSM states IDLE, WAIT, DROP; at most one icache request SHALL be outstanding.
REQ-013 IDLE: if count < DEPTH and !pc_rst, icache_fetch_en=1 (combinational), icache_fetch_addr=fetch_pc, next state WAIT; else remain IDLE.
REQ-014 WAIT: branch_query_addr SHALL equal fetch_pc; on icache_out_en, push {instruction, c, fetch_pc, branch_query_prediction, stack_top} and set fetch_pc <= next_pc.
REQ-015 WAIT response with post-update count < DEPTH (count+1-pop) SHALL issue next fetch same cycle at next_pc and stay WAIT; otherwise go IDLE.
REQ-016 next_pc: opcode 1100011 -> taken ? pc+Bimm : pc+len; 1100111 -> stack_top; 1101111 -> pc+Jimm; else pc+len; len=2 if c else 4.
REQ-017 Bimm/Jimm SHALL be sign-extended then truncated to ADDR_W; all adds wrap modulo 2^ADDR_W.
REQ-018 Pop when count > 0 and out_ready and !pc_rst; outputs registered, instruction_en high exactly one cycle per popped entry, else 0.
REQ-019 No bypass: entry pushed at edge E SHALL appear on instruction_en no earlier than edge E+1; order strictly FIFO.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; push never occurs with count == DEPTH.
REQ-021 pc_rst: queue cleared (count <= 0), fetch_pc <= new_pc, instruction_en <= 0, no fetch issued that cycle; pc_rst SHALL override push, pop and rst-free state.
REQ-022 pc_rst in WAIT without icache_out_en -> DROP; with icache_out_en -> response discarded, IDLE; in IDLE -> IDLE; in DROP -> DROP.
REQ-023 DROP: no fetch issued; on icache_out_en discard response, go IDLE; repeated pc_rst only updates fetch_pc.
REQ-024 rst has priority over pc_rst.

Reset
REQ-025 On rst: state IDLE, fetch_pc 0, count 0, pointers 0, instruction_en 0, all other outputs 0.
REQ-026 First fetch of address 0 SHALL issue in the first cycle after rst deasserts.
REQ-027 A response arriving during or after rst for a pre-reset request SHALL be ignored (rst forces DROP-equivalent discard only if WAIT was active; otherwise ignored).

Structure
REQ-028 Shared package: opcode constants (BRANCH, JALR, JAL), fetch-entry field widths, FSM state encoding.
REQ-029 One sub-module fetch_fifo (DEPTH-entry ring buffer, push/pop/clear/count); next-PC logic and FSM stay in fetch_queue.

Verification
REQ-030 rst, then icache returns ADDI every next cycle, out_ready=1 -> fetch addrs 0,4,8,...; pc_out 0,4,8 with instruction_en each cycle after first.
REQ-031 out_ready=0, DEPTH=4 -> exactly 4 pushes, count=4, icache_fetch_en stays 0; out_ready=1 one cycle -> one pop, one new fetch.
REQ-032 Branch at pc 0x10, Bimm=-8, prediction=1 -> next fetch 0x08, instruction_br_prediction=1; prediction=0, c=1 -> next fetch 0x12.
REQ-033 JALR at 0x20, stack_top=0x1F0 -> next fetch 0x1F0, instruction_addr_prediction=0x1F0; JAL imm=+0x100 at 0x1FFF0 (ADDR_W=17) -> wraps to 0x000F0.
REQ-034 pc_rst in WAIT, new_pc=0x400, response 3 cycles later -> response dropped, count=0, next fetch 0x400 issued cycle after response.
REQ-035 pc_rst coincident with icache_out_en and pop -> nothing pushed, instruction_en=0 next cycle, next fetch at new_pc following cycle.
